// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue sequencer in front of the 32-bit ALU
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_opcode,
    input  logic [31:0]              cmd_operand,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [1:0]               rsp_error,
    output logic [3:0]               alu_opcode,
    output logic [31:0]              alu_operand,
    input  logic [31:0]              alu_result,
    input  logic [1:0]               alu_error,
    output logic                     busy,
    output logic                     halted,
    input  logic                     clear_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0] OP_RESET    = 4'b1100;
    localparam logic [3:0] OP_FEEDBACK = 4'b1110;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RESPOND,
        HALT,
        CLEAR
    } state_t;

    state_t          state;
    state_t          nextState;

    logic [3:0]      memOpcode  [DEPTH];
    logic [31:0]     memOperand [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [CW-1:0]   count;
    logic            doPush;
    logic            doPop;

    // Acceptance never credits a same-cycle pop and is closed while halted or clearing.
    assign cmd_ready  = !rst && (count < FULL_COUNT) && (state != HALT) && (state != CLEAR);
    assign doPush     = cmd_valid && cmd_ready;
    assign doPop      = (state == ISSUE);
    assign rsp_valid  = (state == RESPOND);
    assign halted     = (state == HALT);
    assign busy       = (count != '0) || (state != IDLE);
    assign fifo_count = count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and ALU drive; the ALU holds its accumulator unless issuing or clearing.
    always_comb begin
        nextState   = state;
        alu_opcode  = OP_FEEDBACK;
        alu_operand = '0;
        case (state)
            IDLE: begin
                if (count != '0) nextState = ISSUE;
            end
            ISSUE: begin
                alu_opcode  = memOpcode[rdPtr];
                alu_operand = memOperand[rdPtr];
                nextState   = RESPOND;
            end
            RESPOND: begin
                if (rsp_ready) begin
                    if (rsp_error != 2'b00)  nextState = HALT;
                    else if (count != '0)    nextState = ISSUE;
                    else                     nextState = IDLE;
                end
            end
            HALT: begin
                if (clear_err) nextState = CLEAR;
            end
            CLEAR: begin
                alu_opcode = OP_RESET;
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (rst) begin
            alu_opcode  = OP_RESET;
            alu_operand = '0;
        end
    end

    // Command storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            memOpcode[wrPtr]  <= cmd_opcode;
            memOperand[wrPtr] <= cmd_operand;
        end
    end

    // FIFO pointers/count and response capture at the close of ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            rsp_result <= '0;
            rsp_error  <= 2'b00;
        end else begin
            if (state == CLEAR) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (doPush) wrPtr <= wrPtr + AW'(1);
                if (doPop)  rdPtr <= rdPtr + AW'(1);
                case ({doPush, doPop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
            if (state == ISSUE) begin
                rsp_result <= alu_result;
                rsp_error  <= alu_error;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [31:0] cmd_operand = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_operand;
    logic [31:0] aluResult;
    logic [1:0]  aluError;
    logic        busy;
    logic        halted;
    logic        clear_err = 1'b0;
    logic [2:0]  fifo_count;

    logic [31:0] aluAcc;
    logic [63:0] wide;

    int compareCount = 0;
    int mismatchCount = 0;
    int pushedCnt = 0;

    logic [3:0]  pendOp[$];
    logic [31:0] pendArg[$];
    logic [31:0] gotRes[$];
    logic [1:0]  gotErr[$];

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_opcode(alu_opcode), .alu_operand(alu_operand),
        .alu_result(aluResult), .alu_error(aluError),
        .busy(busy), .halted(halted), .clear_err(clear_err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // ALU model: combinational result from accumulator and drive.
    always_comb begin
        aluResult = aluAcc;
        aluError  = 2'b00;
        wide      = '0;
        case (alu_opcode)
            4'b0000: begin
                wide = {32'b0, aluAcc} + {32'b0, alu_operand};
                aluResult = wide[31:0];
                if (wide[32]) aluError = 2'b10;
            end
            4'b0001: aluResult = aluAcc - alu_operand;
            4'b0010: begin
                wide = {32'b0, aluAcc} * {32'b0, alu_operand};
                aluResult = wide[31:0];
                if (wide[63:32] != 32'b0) aluError = 2'b10;
            end
            4'b0011: begin
                if (alu_operand == 32'b0) aluError = 2'b01;
                else aluResult = aluAcc / alu_operand;
            end
            4'b1100: aluResult = 32'h0;
            4'b1101: aluResult = 32'hFFFF_FFFF;
            default: aluResult = aluAcc;
        endcase
    end

    // ALU accumulator: no reset of its own.
    always_ff @(posedge clk) aluAcc <= aluResult;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [3:0] op, input logic [31:0] arg);
        pendOp.push_back(op);
        pendArg.push_back(arg);
    endtask

    task automatic loadNext();
        if (pendOp.size() > 0) begin
            cmd_opcode  = pendOp.pop_front();
            cmd_operand = pendArg.pop_front();
            cmd_valid   = 1'b1;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic step();
        bit pushNow;
        pushNow = cmd_valid && cmd_ready;
        if (rsp_valid && rsp_ready) begin
            gotRes.push_back(rsp_result);
            gotErr.push_back(rsp_error);
        end
        tick();
        if (pushNow) begin
            pushedCnt++;
            loadNext();
        end
    endtask

    task automatic runUntil(input string tag, input int n, input int budget);
        int cycles;
        cycles = 0;
        while (gotRes.size() < n && cycles < budget) begin
            step();
            cycles++;
        end
        checkVal(tag, gotRes.size(), n);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        checkVal("rst_count", fifo_count, 0);
        checkVal("rst_cmd_ready", cmd_ready, 0);
        checkVal("rst_rsp_valid", rsp_valid, 0);
        checkVal("rst_rsp_result", rsp_result, 0);
        checkVal("rst_rsp_error", rsp_error, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_halted", halted, 0);
        checkVal("rst_alu_opcode", alu_opcode, 4'b1100);
        rst = 1'b0;
        #1;
        checkVal("post_rst_ready", cmd_ready, 1);
        checkVal("post_rst_opcode", alu_opcode, 4'b1110);

        // Basic sequence: add 5, mult 3, sub 4
        gotRes.delete(); gotErr.delete();
        enqueue(4'b0000, 5);
        enqueue(4'b0010, 3);
        enqueue(4'b0001, 4);
        rsp_ready = 1'b1;
        loadNext();
        step();
        checkVal("lat1_valid", rsp_valid, 0);
        step();
        checkVal("lat2_valid", rsp_valid, 0);
        step();
        checkVal("lat3_valid", rsp_valid, 1);
        runUntil("basic_n", 3, 30);
        if (gotRes.size() == 3) begin
            checkVal("basic_r0", gotRes[0], 5);
            checkVal("basic_r1", gotRes[1], 15);
            checkVal("basic_r2", gotRes[2], 11);
            checkVal("basic_e", {gotErr[0], gotErr[1], gotErr[2]}, 0);
        end
        checkVal("basic_busy", busy, 0);

        // Backpressure with a full FIFO: accumulator starts at 11
        gotRes.delete(); gotErr.delete();
        pushedCnt = 0;
        rsp_ready = 1'b0;
        for (int k = 1; k <= 6; k++) enqueue(4'b0000, k);
        loadNext();
        for (int i = 0; i < 20 && fifo_count != 3'd4; i++) step();
        checkVal("full_count", fifo_count, 4);
        checkVal("full_ready", cmd_ready, 0);
        checkVal("full_pushed", pushedCnt, 5);
        checkVal("full_rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            checkVal("hold_result", rsp_result, 12);
        end
        checkVal("hold_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        runUntil("bp_n", 6, 60);
        if (gotRes.size() == 6) begin
            checkVal("bp_r0", gotRes[0], 12);
            checkVal("bp_r1", gotRes[1], 14);
            checkVal("bp_r2", gotRes[2], 17);
            checkVal("bp_r3", gotRes[3], 21);
            checkVal("bp_r4", gotRes[4], 26);
            checkVal("bp_r5", gotRes[5], 32);
        end
        checkVal("bp_pushed", pushedCnt, 6);

        // Divide by zero with a trailing command left queued
        gotRes.delete(); gotErr.delete();
        enqueue(4'b1100, 0);
        enqueue(4'b0000, 15);
        enqueue(4'b0011, 0);
        enqueue(4'b0000, 1);
        loadNext();
        runUntil("dz_n", 3, 40);
        if (gotRes.size() == 3) begin
            checkVal("dz_r0", gotRes[0], 0);
            checkVal("dz_r1", gotRes[1], 15);
            checkVal("dz_e1", gotErr[1], 0);
            checkVal("dz_e2", gotErr[2], 2'b01);
        end
        checkVal("dz_halted", halted, 1);
        checkVal("dz_ready", cmd_ready, 0);
        checkVal("dz_count", fifo_count, 1);
        for (int i = 0; i < 3; i++) step();
        checkVal("dz_still_halted", halted, 1);
        checkVal("dz_still_count", fifo_count, 1);
        checkVal("dz_no_rsp", rsp_valid, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checkVal("clr_opcode", alu_opcode, 4'b1100);
        checkVal("clr_halted", halted, 0);
        checkVal("clr_ready", cmd_ready, 0);
        tick();
        checkVal("clr_count", fifo_count, 0);
        checkVal("clr_busy", busy, 0);
        checkVal("clr_idle_opcode", alu_opcode, 4'b1110);
        gotRes.delete(); gotErr.delete();
        enqueue(4'b0000, 7);
        loadNext();
        runUntil("add7_n", 1, 20);
        if (gotRes.size() == 1) begin
            checkVal("add7_r", gotRes[0], 7);
            checkVal("add7_e", gotErr[0], 0);
        end

        // Overflow; clear_err while not halted is ignored
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checkVal("stray_clr_halted", halted, 0);
        checkVal("stray_clr_busy", busy, 0);
        checkVal("stray_clr_ready", cmd_ready, 1);
        gotRes.delete(); gotErr.delete();
        enqueue(4'b1101, 0);
        enqueue(4'b0000, 1);
        loadNext();
        runUntil("ovf_n", 2, 30);
        if (gotRes.size() == 2) begin
            checkVal("ovf_r0", gotRes[0], 32'hFFFF_FFFF);
            checkVal("ovf_e0", gotErr[0], 0);
            checkVal("ovf_r1", gotRes[1], 0);
            checkVal("ovf_e1", gotErr[1], 2'b10);
        end
        checkVal("ovf_halted", halted, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tick();
        checkVal("ovf_recovered", halted, 0);

        // Reset during RESPOND with two entries queued
        gotRes.delete(); gotErr.delete();
        rsp_ready = 1'b0;
        enqueue(4'b0000, 1);
        enqueue(4'b0000, 2);
        enqueue(4'b0000, 3);
        loadNext();
        for (int i = 0; i < 20 && !(rsp_valid && fifo_count == 3'd2); i++) step();
        checkVal("mid_rsp_valid", rsp_valid, 1);
        checkVal("mid_count", fifo_count, 2);
        rst = 1'b1;
        cmd_valid = 1'b0;
        pendOp.delete(); pendArg.delete();
        #1;
        checkVal("mid_rst_opcode_comb", alu_opcode, 4'b1100);
        tick();
        checkVal("mid_rst_rsp_valid", rsp_valid, 0);
        checkVal("mid_rst_count", fifo_count, 0);
        checkVal("mid_rst_opcode", alu_opcode, 4'b1100);
        checkVal("mid_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        enqueue(4'b1110, 0);
        loadNext();
        runUntil("fb_n", 1, 20);
        if (gotRes.size() == 1) begin
            checkVal("fb_r", gotRes[0], 0);
            checkVal("fb_e", gotErr[0], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
